// File: rtl/qtcore_scan_ctrl_if.sv
// rtl/qtcore_scan_ctrl_if.sv - host byte streams between host and qtcore scan controller
interface qtcore_scan_ctrl_if;
  logic [7:0] in_data_in;
  logic       in_valid_in;
  logic       in_ready_out;
  logic [7:0] out_data_out;
  logic       out_valid_out;
  logic       out_ready_in;

  modport master (
    output in_data_in,
    output in_valid_in,
    input  in_ready_out,
    input  out_data_out,
    input  out_valid_out,
    output out_ready_in
  );

  modport slave (
    input  in_data_in,
    input  in_valid_in,
    output in_ready_out,
    output out_data_out,
    output out_valid_out,
    input  out_ready_in
  );
endinterface

// File: rtl/qtcore_scan_ctrl.sv
// rtl/qtcore_scan_ctrl.sv - byte-stream scan-chain load/unload and proc_en run controller
module qtcore_scan_ctrl #(
  parameter int CHAIN_LEN = 176,
  parameter int RUNW      = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            start_in,
  input  logic            run_in,
  input  logic [RUNW-1:0] run_cycles_in,
  output logic            busy_out,
  output logic            done_out,
  qtcore_scan_ctrl_if.slave host,
  output logic            scan_enable_out,
  output logic            scan_data_out,
  input  logic            scan_data_in,
  output logic            proc_en_out
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      shreg_q;
  logic [2:0]      bit_cnt_q;
  logic [BCW-1:0]  byte_cnt_q;
  logic [RUNW-1:0] run_cnt_q;
  logic [7:0]      out_data_q;
  logic            out_valid_q;
  logic            done_q;
  logic            in_accept;
  logic            in_ready;

  // One-byte out buffer: a new byte may only be taken once the previous capture has left.
  assign in_ready  = (state_q == ST_LOAD) && !out_valid_q;
  assign in_accept = in_ready && host.in_valid_in;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start beats run when both are requested in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_LOAD;
        end else if (run_in && (run_cycles_in != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (in_accept) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == 3'd7) begin
          state_d = (byte_cnt_q == LAST_BYTE) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (run_cnt_q <= RUNW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so the chain never sees host-input glitches.
  always_comb begin
    busy_out        = 1'b0;
    scan_enable_out = 1'b0;
    scan_data_out   = 1'b0;
    proc_en_out     = 1'b0;
    case (state_q)
      ST_IDLE:  busy_out = 1'b0;
      ST_SHIFT: begin
        busy_out        = 1'b1;
        scan_enable_out = 1'b1;
        scan_data_out   = shreg_q[7];
      end
      ST_RUN: begin
        busy_out    = 1'b1;
        proc_en_out = 1'b1;
      end
      default:  busy_out = 1'b1;
    endcase
  end

  // Datapath: shift register, counters, out buffer and done pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      run_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && host.out_ready_in) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            byte_cnt_q <= '0;
          end else if (run_in) begin
            run_cnt_q <= run_cycles_in;
            if (run_cycles_in == '0) begin
              done_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (in_accept) begin
            shreg_q   <= host.in_data_in;
            bit_cnt_q <= '0;
          end
        end
        ST_SHIFT: begin
          // Outgoing MSB leaves on this edge while the displaced chain bit enters at the LSB.
          shreg_q   <= {shreg_q[6:0], scan_data_in};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            out_data_q  <= {shreg_q[6:0], scan_data_in};
            out_valid_q <= 1'b1;
            byte_cnt_q  <= byte_cnt_q + BCW'(1);
          end
        end
        ST_DRAIN: begin
          if (!out_valid_q) begin
            done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          run_cnt_q <= run_cnt_q - RUNW'(1);
          if (run_cnt_q <= RUNW'(1)) begin
            done_q <= 1'b1;
          end
        end
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign done_out           = done_q;
  assign host.in_ready_out  = in_ready;
  assign host.out_data_out  = out_data_q;
  assign host.out_valid_out = out_valid_q;

endmodule
